// File: rtl/ifetch_bp.sv
// Instruction-fetch stage: PC register, branch decode of the fetched word, 2-bit BHT
// prediction, and redirect/flush on JR or EX-reported mispredictions.
module ifetch_bp #(
  parameter int                 ADDR_W   = 16,
  parameter int                 BHT_BITS = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [1:0]         INIT_CTR = 2'b01
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_i,
  input  logic [15:0]       instr_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  input  logic              res_valid_i,
  input  logic [ADDR_W-1:0] res_pc_i,
  input  logic              res_taken_i,
  input  logic              res_pred_i,
  input  logic [ADDR_W-1:0] res_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pcplus1_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              flush_o
);

  typedef enum logic [1:0] {BUBBLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  localparam int                BHT_N = 1 << BHT_BITS;
  localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] lock_q, lock_d;
  logic [1:0]        bht_q [BHT_N];

  logic [4:0]          op;
  logic                is_b, is_bc, pred_taken;
  logic [ADDR_W-1:0]   imm_ext, target, pc_inc, fix_pc, redir_pc, next_pc;
  logic                mispred, redirect;
  logic [BHT_BITS-1:0] fetch_idx, res_idx;

  assign op        = instr_i[15:11];
  assign is_b      = (op == 5'b00010);
  assign is_bc     = (op == 5'b00100) || (op == 5'b00101);
  assign fetch_idx = pc_q[BHT_BITS-1:0];
  assign res_idx   = res_pc_i[BHT_BITS-1:0];

  always_comb begin
    imm_ext = {{(ADDR_W-8){instr_i[7]}}, instr_i[7:0]};
    if (is_b) imm_ext = {{(ADDR_W-11){instr_i[10]}}, instr_i[10:0]};
  end

  assign pc_inc     = pc_q + ONE;
  assign target     = pc_inc + imm_ext;
  assign pred_taken = (state_q != BUBBLE) && (is_b || (is_bc && bht_q[fetch_idx][1]));

  assign mispred  = res_valid_i && (res_taken_i != res_pred_i);
  assign fix_pc   = res_taken_i ? res_target_i : (res_pc_i + ONE);
  assign redirect = jr_i || mispred;
  assign redir_pc = jr_i ? jr_addr_i : fix_pc;

  // A pending redirect only outranks prediction; a fresh jr/mispred still beats it.
  always_comb begin
    next_pc = pc_inc;
    if (redirect)              next_pc = redir_pc;
    else if (state_q == PEND)  next_pc = pend_q;
    else if (pred_taken)       next_pc = target;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    lock_d  = lock_q;
    case (state_q)
      BUBBLE: begin
        if (redirect) begin
          pend_d  = redir_pc;
          state_d = PEND;
        end else if (!stall_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall_i) begin
          pc_d   = next_pc;
          lock_d = pc_q;
        end else if (redirect) begin
          pend_d  = redir_pc;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!stall_i) begin
          pc_d    = next_pc;
          lock_d  = pc_q;
          state_d = RUN;
        end else if (redirect) begin
          pend_d = redir_pc;
        end
      end
      default: state_d = BUBBLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= BUBBLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      lock_q  <= lock_d;
    end
  end

  // Counter training is independent of stall; a same-cycle lookup sees the old value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= INIT_CTR;
    end else if (res_valid_i) begin
      if (res_taken_i && bht_q[res_idx] != 2'b11)
        bht_q[res_idx] <= bht_q[res_idx] + 2'b01;
      else if (!res_taken_i && bht_q[res_idx] != 2'b00)
        bht_q[res_idx] <= bht_q[res_idx] - 2'b01;
    end
  end

  assign pc_o         = pc_q;
  assign pcplus1_o    = pc_inc;
  assign pred_taken_o = pred_taken;
  assign flush_o      = redirect;
  assign epc_o        = (res_valid_i || jr_i) ? lock_q : pc_q;

endmodule

// File: tb/tb_ifetch_bp.sv
// Directed bench for ifetch_bp: reset/bubble, unconditional and conditional prediction,
// BHT training and saturation, stalled redirects, PC wrap and reset while pending.
module tb_ifetch_bp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_i;
  logic [15:0] instr_i;
  logic        jr_i;
  logic [15:0] jr_addr_i;
  logic        res_valid_i;
  logic [15:0] res_pc_i;
  logic        res_taken_i;
  logic        res_pred_i;
  logic [15:0] res_target_i;
  logic [15:0] pc_o, pcplus1_o, epc_o;
  logic        pred_taken_o, flush_o;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] BM2  = 16'h17FE;  // B -2
  localparam logic [15:0] BEQ4 = 16'h2004;  // BEQZ +4

  always #5 CLK = ~CLK;

  ifetch_bp dut (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .instr_i(instr_i),
    .jr_i(jr_i), .jr_addr_i(jr_addr_i), .res_valid_i(res_valid_i),
    .res_pc_i(res_pc_i), .res_taken_i(res_taken_i), .res_pred_i(res_pred_i),
    .res_target_i(res_target_i), .pc_o(pc_o), .pcplus1_o(pcplus1_o),
    .pred_taken_o(pred_taken_o), .epc_o(epc_o), .flush_o(flush_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and leave inputs idle.
  task automatic step();
    @(posedge CLK);
    #1;
    stall_i = 1'b0; instr_i = NOP; jr_i = 1'b0; jr_addr_i = '0;
    res_valid_i = 1'b0; res_pc_i = '0; res_taken_i = 1'b0; res_pred_i = 1'b0;
    res_target_i = '0;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic do_jr(input logic [15:0] a);
    jr_i = 1'b1; jr_addr_i = a;
    step();
  endtask

  initial begin
    RST = 1'b0; stall_i = 1'b0; instr_i = NOP; jr_i = 1'b0; jr_addr_i = '0;
    res_valid_i = 1'b0; res_pc_i = '0; res_taken_i = 1'b0; res_pred_i = 1'b0;
    res_target_i = '0;
    repeat (2) @(posedge CLK);
    #1;
    look();
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_pred", {15'b0, pred_taken_o}, 16'h0);
    chk("rst_flush", {15'b0, flush_o}, 16'h0);
    RST = 1'b1;

    // Bubble: even a B word is not predicted, PC holds.
    instr_i = BM2; look();
    chk("bub_pc", pc_o, 16'h0000);
    chk("bub_pred", {15'b0, pred_taken_o}, 16'h0);
    step(); look();
    chk("run_pc0", pc_o, 16'h0000);
    chk("pcplus1", pcplus1_o, 16'h0001);
    step(); look();
    chk("run_pc1", pc_o, 16'h0001);
    step(); look();
    chk("run_pc2", pc_o, 16'h0002);
    step(); look();
    chk("run_pc3", pc_o, 16'h0003);
    chk("nop_pred", {15'b0, pred_taken_o}, 16'h0);

    // JR: flush and epc from last locked PC.
    jr_i = 1'b1; jr_addr_i = 16'h0010; look();
    chk("jr_flush", {15'b0, flush_o}, 16'h1);
    chk("jr_epc", epc_o, 16'h0002);
    step(); look();
    chk("jr_pc", pc_o, 16'h0010);

    // Unconditional backward branch.
    instr_i = BM2; look();
    chk("b_pred", {15'b0, pred_taken_o}, 16'h1);
    chk("b_flush", {15'b0, flush_o}, 16'h0);
    chk("b_epc", epc_o, 16'h0010);
    step(); look();
    chk("b_target", pc_o, 16'h000F);

    // BEQZ at 0x20 with counter weakly not-taken.
    do_jr(16'h0020);
    instr_i = BEQ4; look();
    chk("bc_pred0", {15'b0, pred_taken_o}, 16'h0);
    step(); look();
    chk("bc_fall", pc_o, 16'h0021);
    res_valid_i = 1'b1; res_pc_i = 16'h0020; res_taken_i = 1'b1; res_pred_i = 1'b0;
    res_target_i = 16'h0025; look();
    chk("mp1_flush", {15'b0, flush_o}, 16'h1);
    chk("mp1_epc", epc_o, 16'h0020);
    step(); look();
    chk("mp1_pc", pc_o, 16'h0025);
    res_valid_i = 1'b1; res_pc_i = 16'h0020; res_taken_i = 1'b1; res_pred_i = 1'b0;
    res_target_i = 16'h0025; look();
    chk("mp2_flush", {15'b0, flush_o}, 16'h1);
    step(); look();
    chk("mp2_pc", pc_o, 16'h0025);
    do_jr(16'h0020);
    instr_i = BEQ4; look();
    chk("bc_pred1", {15'b0, pred_taken_o}, 16'h1);
    step(); look();
    chk("bc_taken", pc_o, 16'h0025);

    // Correct taken resolution at a saturated counter: no flush, stays 11.
    res_valid_i = 1'b1; res_pc_i = 16'h0020; res_taken_i = 1'b1; res_pred_i = 1'b1;
    res_target_i = 16'h0025; look();
    chk("ok_flush", {15'b0, flush_o}, 16'h0);
    step(); look();
    chk("ok_pc", pc_o, 16'h0026);

    // Mispredict arriving during a 3-cycle stall.
    stall_i = 1'b1; res_valid_i = 1'b1; res_pc_i = 16'h0030; res_taken_i = 1'b0;
    res_pred_i = 1'b1; res_target_i = 16'h0099; look();
    chk("st1_flush", {15'b0, flush_o}, 16'h1);
    chk("st1_pc", pc_o, 16'h0026);
    step(); stall_i = 1'b1; look();
    chk("st2_flush", {15'b0, flush_o}, 16'h0);
    chk("st2_pc", pc_o, 16'h0026);
    step(); stall_i = 1'b1; look();
    chk("st3_pc", pc_o, 16'h0026);
    step(); look();
    chk("st_rel_pc", pc_o, 16'h0026);
    step(); look();
    chk("st_fix_pc", pc_o, 16'h0031);

    // Counter now 10: still predicts taken; same-cycle update is not visible.
    do_jr(16'h0020);
    instr_i = BEQ4; jr_i = 1'b1; jr_addr_i = 16'h0100;
    res_valid_i = 1'b1; res_pc_i = 16'h0040; res_taken_i = 1'b0; res_pred_i = 1'b1;
    res_target_i = 16'h0077; look();
    chk("sat_pred", {15'b0, pred_taken_o}, 16'h1);
    chk("jrmp_flush", {15'b0, flush_o}, 16'h1);
    step(); look();
    chk("jrmp_pc", pc_o, 16'h0100);
    do_jr(16'h0020);
    instr_i = BEQ4; look();
    chk("bht_upd", {15'b0, pred_taken_o}, 16'h0);

    // PC wrap.
    do_jr(16'hFFFF); look();
    chk("wrap_pre", pc_o, 16'hFFFF);
    chk("wrap_plus1", pcplus1_o, 16'h0000);
    step(); look();
    chk("wrap_pc", pc_o, 16'h0000);

    // Reset asserted while a redirect is pending.
    step(); look();
    stall_i = 1'b1; jr_i = 1'b1; jr_addr_i = 16'h0055;
    step(); stall_i = 1'b1; look();
    RST = 1'b0; #1;
    chk("prst_pc", pc_o, 16'h0000);
    chk("prst_flush", {15'b0, flush_o}, 16'h0);
    step(); RST = 1'b1; look();
    chk("prst_bub", pc_o, 16'h0000);
    step(); look();
    chk("prst_hold", pc_o, 16'h0000);
    step(); look();
    chk("prst_run", pc_o, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
